// File: rtl/d_cache_pkg.sv
// Shared types and helpers for the set-associative data cache.
// FLUSH state exists only when D_CACHE_FLUSH_EN is defined.
package d_cache_pkg;

    typedef enum logic [2:0] {
        ST_READY,
        ST_WRITEBACK,
        ST_REFILL,
        ST_RESPOND
`ifdef D_CACHE_FLUSH_EN
        , ST_FLUSH
`endif
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // mask[2] selects zero-extension; size 2'b11 behaves as a word access.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  mask,
                                                input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (mask[1:0])
            SIZE_BYTE: r = mask[2] ? {24'b0, b} : {{24{b[7]}}, b};
            SIZE_HALF: r = mask[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default:   r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = old;
        case (size)
            SIZE_BYTE: r[{off, 3'b000} +: 8] = wdata[7:0];
            SIZE_HALF: begin
                if (off[1]) r[31:16] = wdata[15:0];
                else        r[15:0]  = wdata[15:0];
            end
            default:   r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/d_cache_plru.sv
// Per-set tree pseudo-LRU state: update on access, victim lookup for a set.
module d_cache_plru #(
    parameter int unsigned WAYS        = 2,
    parameter int unsigned INDEX_WIDTH = 6,
    localparam int unsigned WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   access_i,
    input  logic [INDEX_WIDTH-1:0] access_set_i,
    input  logic [WAY_W-1:0]       access_way_i,
    input  logic [INDEX_WIDTH-1:0] lookup_set_i,
    output logic [WAY_W-1:0]       victim_way_o
);

    localparam int unsigned BITS = (WAYS > 1) ? WAYS - 1 : 1;

    logic [BITS-1:0] bits_q [2**INDEX_WIDTH];
    logic [BITS-1:0] upd;
    logic [BITS-1:0] cur;

    assign cur = bits_q[lookup_set_i];

    // Each tree bit points toward the less recently used side.
    generate
        if (WAYS == 4) begin : g_four
            always_comb begin
                upd    = bits_q[access_set_i];
                upd[0] = ~access_way_i[1];
                if (access_way_i[1]) upd[2] = ~access_way_i[0];
                else                 upd[1] = ~access_way_i[0];
            end
            assign victim_way_o = cur[0] ? {1'b1, cur[2]} : {1'b0, cur[1]};
        end else if (WAYS == 2) begin : g_two
            assign upd          = ~access_way_i;
            assign victim_way_o = cur;
        end else begin : g_one
            assign upd          = '0;
            assign victim_way_o = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned s = 0; s < 2**INDEX_WIDTH; s++) bits_q[s] <= '0;
        end else if (access_i) begin
            bits_q[access_set_i] <= upd;
        end
    end

endmodule

// File: rtl/d_cache_assoc.sv
// N-way set-associative write-back, write-allocate data cache with tree PLRU.
// Optional full flush enabled by defining D_CACHE_FLUSH_EN.
module d_cache_assoc
    import d_cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned ADDRESS_WIDTH     = 32,
    parameter int unsigned WORD_OFFSET_WIDTH = 2,
    parameter int unsigned INDEX_WIDTH       = 6,
    parameter int unsigned WAYS              = 2,
    parameter int unsigned TAG_WIDTH         = ADDRESS_WIDTH - INDEX_WIDTH - WORD_OFFSET_WIDTH - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic [2:0]               mem_mask_i,
    input  logic [ADDRESS_WIDTH-1:0] addr_i,
    input  logic                     read_write_i,
    input  logic [DATA_WIDTH-1:0]    write_data_i,
    input  logic                     flush_i,
    output logic                     ready_o,
    output logic                     valid_o,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic                     flush_done_o,
    output logic                     mem_valid_o,
    output logic                     mem_read_write_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_data_o,
    input  logic                     mem_valid_i,
    input  logic                     mem_last_i,
    input  logic [DATA_WIDTH-1:0]    mem_data_i
);

    localparam int unsigned WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned LINE_W  = WAY_W + INDEX_WIDTH;
    localparam int unsigned WADDR_W = LINE_W + WORD_OFFSET_WIDTH;
    localparam int unsigned IDX_LO  = WORD_OFFSET_WIDTH + 2;
    localparam int unsigned TAG_LO  = IDX_LO + INDEX_WIDTH;
    localparam int unsigned LOFF_W  = WORD_OFFSET_WIDTH + 2;

    logic [DATA_WIDTH-1:0] data_mem [2**WADDR_W];
    logic [TAG_WIDTH-1:0]  tag_mem  [2**LINE_W];
    logic [2**LINE_W-1:0]  valid_q, valid_d, dirty_q, dirty_d;

    state_e                         state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]       req_addr_q, req_addr_d;
    logic                           req_rw_q, req_rw_d;
    logic [2:0]                     req_mask_q, req_mask_d;
    logic [DATA_WIDTH-1:0]          req_wdata_q, req_wdata_d;
    logic [WAY_W-1:0]               way_q, way_d;
    logic [WORD_OFFSET_WIDTH-1:0]   beat_q, beat_d;
    logic [DATA_WIDTH-1:0]          resp_q, resp_d;
    logic                           out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]          data_q, data_d;

    logic                           dw_en;
    logic [WADDR_W-1:0]             dw_addr;
    logic [DATA_WIDTH-1:0]          dw_data;
    logic                           tag_we;
    logic [LINE_W-1:0]              tag_wa;
    logic [TAG_WIDTH-1:0]           tag_wd;
    logic                           plru_acc;
    logic [INDEX_WIDTH-1:0]         plru_set;
    logic [WAY_W-1:0]               plru_way, plru_victim;

    logic [INDEX_WIDTH-1:0]         a_set, r_set;
    logic [TAG_WIDTH-1:0]           a_tag, r_tag;
    logic [WORD_OFFSET_WIDTH-1:0]   a_off, r_off;
    logic                           hit, inv_found;
    logic [WAY_W-1:0]               hit_way, inv_way, victim_way;
    logic [DATA_WIDTH-1:0]          hit_word, beat_word;

    assign a_set = addr_i[IDX_LO +: INDEX_WIDTH];
    assign a_tag = addr_i[TAG_LO +: TAG_WIDTH];
    assign a_off = addr_i[2 +: WORD_OFFSET_WIDTH];
    assign r_set = req_addr_q[IDX_LO +: INDEX_WIDTH];
    assign r_tag = req_addr_q[TAG_LO +: TAG_WIDTH];
    assign r_off = req_addr_q[2 +: WORD_OFFSET_WIDTH];

    d_cache_plru #(
        .WAYS        (WAYS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_plru (
        .clk          (clk),
        .rst          (rst),
        .access_i     (plru_acc),
        .access_set_i (plru_set),
        .access_way_i (plru_way),
        .lookup_set_i (a_set),
        .victim_way_o (plru_victim)
    );

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[{WAY_W'(w), a_set}] && tag_mem[{WAY_W'(w), a_set}] == a_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[{WAY_W'(w), a_set}] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign victim_way = inv_found ? inv_way : plru_victim;
    assign hit_word   = data_mem[{hit_way, a_set, a_off}];
    // A write miss merges its store into the refill beat carrying the target word.
    assign beat_word  = (req_rw_q == WRITE && beat_q == r_off)
                      ? store_merge(mem_data_i, req_wdata_q, req_mask_q[1:0], req_addr_q[1:0])
                      : mem_data_i;

`ifdef D_CACHE_FLUSH_EN
    logic [LINE_W-1:0]      fl_q, fl_d;
    logic [INDEX_WIDTH-1:0] fl_set;
    logic [WAY_W-1:0]       fl_way;
    logic [LINE_W-1:0]      fl_line;
    logic                   flush_done_q, flush_done_d;

    assign fl_set       = fl_q[WAY_W +: INDEX_WIDTH];
    assign fl_way       = fl_q[WAY_W-1:0];
    assign fl_line      = {fl_way, fl_set};
    assign flush_done_o = flush_done_q;
`else
    logic unused_flush;
    assign unused_flush = flush_i;
    assign flush_done_o = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        req_addr_d       = req_addr_q;
        req_rw_d         = req_rw_q;
        req_mask_d       = req_mask_q;
        req_wdata_d      = req_wdata_q;
        way_d            = way_q;
        beat_d           = beat_q;
        resp_d           = resp_q;
        out_valid_d      = 1'b0;
        data_d           = data_q;
        valid_d          = valid_q;
        dirty_d          = dirty_q;
        dw_en            = 1'b0;
        dw_addr          = '0;
        dw_data          = '0;
        tag_we           = 1'b0;
        tag_wa           = '0;
        tag_wd           = '0;
        plru_acc         = 1'b0;
        plru_set         = '0;
        plru_way         = '0;
        mem_valid_o      = 1'b0;
        mem_read_write_o = 1'b0;
        mem_addr_o       = '0;
        mem_data_o       = '0;
`ifdef D_CACHE_FLUSH_EN
        fl_d             = fl_q;
        flush_done_d     = 1'b0;
`endif
        case (state_q)
            ST_READY: begin
                if (valid_i) begin
                    if (hit) begin
                        out_valid_d = 1'b1;
                        plru_acc    = 1'b1;
                        plru_set    = a_set;
                        plru_way    = hit_way;
                        if (read_write_i == READ) begin
                            data_d = load_extend(hit_word, mem_mask_i, addr_i[1:0]);
                        end else begin
                            dw_en   = 1'b1;
                            dw_addr = {hit_way, a_set, a_off};
                            dw_data = store_merge(hit_word, write_data_i, mem_mask_i[1:0], addr_i[1:0]);
                            dirty_d[{hit_way, a_set}] = 1'b1;
                        end
                    end else begin
                        req_addr_d  = addr_i;
                        req_rw_d    = read_write_i;
                        req_mask_d  = mem_mask_i;
                        req_wdata_d = write_data_i;
                        way_d       = victim_way;
                        beat_d      = '0;
                        state_d     = (valid_q[{victim_way, a_set}] && dirty_q[{victim_way, a_set}])
                                    ? ST_WRITEBACK : ST_REFILL;
                    end
                end
`ifdef D_CACHE_FLUSH_EN
                else if (flush_i) begin
                    fl_d    = '0;
                    beat_d  = '0;
                    state_d = ST_FLUSH;
                end
`endif
            end
            ST_WRITEBACK: begin
                mem_valid_o      = 1'b1;
                mem_read_write_o = WRITE;
                mem_addr_o       = {tag_mem[{way_q, r_set}], r_set, {LOFF_W{1'b0}}};
                mem_data_o       = data_mem[{way_q, r_set, beat_q}];
                if (mem_valid_i) begin
                    beat_d = beat_q + 1'b1;
                    if (mem_last_i) begin
                        beat_d  = '0;
                        state_d = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                mem_valid_o      = 1'b1;
                mem_read_write_o = READ;
                mem_addr_o       = {r_tag, r_set, {LOFF_W{1'b0}}};
                if (mem_valid_i) begin
                    dw_en   = 1'b1;
                    dw_addr = {way_q, r_set, beat_q};
                    dw_data = beat_word;
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == r_off) resp_d = beat_word;
                    if (mem_last_i) begin
                        beat_d                 = '0;
                        tag_we                 = 1'b1;
                        tag_wa                 = {way_q, r_set};
                        tag_wd                 = r_tag;
                        valid_d[{way_q, r_set}] = 1'b1;
                        dirty_d[{way_q, r_set}] = (req_rw_q == WRITE);
                        plru_acc               = 1'b1;
                        plru_set               = r_set;
                        plru_way               = way_q;
                        out_valid_d            = 1'b1;
                        if (req_rw_q == READ) begin
                            data_d = load_extend((beat_q == r_off) ? beat_word : resp_q,
                                                 req_mask_q, req_addr_q[1:0]);
                        end
                        state_d = ST_RESPOND;
                    end
                end
            end
            ST_RESPOND: begin
                state_d = ST_READY;
            end
`ifdef D_CACHE_FLUSH_EN
            ST_FLUSH: begin
                if (valid_q[fl_line] && dirty_q[fl_line]) begin
                    mem_valid_o      = 1'b1;
                    mem_read_write_o = WRITE;
                    mem_addr_o       = {tag_mem[fl_line], fl_set, {LOFF_W{1'b0}}};
                    mem_data_o       = data_mem[{fl_line, beat_q}];
                end
                // Clean or invalid lines retire in one cycle; dirty ones after their burst.
                if (!(valid_q[fl_line] && dirty_q[fl_line]) || (mem_valid_i && mem_last_i)) begin
                    beat_d           = '0;
                    valid_d[fl_line] = 1'b0;
                    dirty_d[fl_line] = 1'b0;
                    fl_d             = fl_q + 1'b1;
                    if (&fl_q) begin
                        flush_done_d = 1'b1;
                        state_d      = ST_READY;
                    end
                end else if (mem_valid_i) begin
                    beat_d = beat_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_READY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_READY;
            req_addr_q   <= '0;
            req_rw_q     <= 1'b0;
            req_mask_q   <= '0;
            req_wdata_q  <= '0;
            way_q        <= '0;
            beat_q       <= '0;
            resp_q       <= '0;
            out_valid_q  <= 1'b0;
            data_q       <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
`ifdef D_CACHE_FLUSH_EN
            fl_q         <= '0;
            flush_done_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            req_rw_q     <= req_rw_d;
            req_mask_q   <= req_mask_d;
            req_wdata_q  <= req_wdata_d;
            way_q        <= way_d;
            beat_q       <= beat_d;
            resp_q       <= resp_d;
            out_valid_q  <= out_valid_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
`ifdef D_CACHE_FLUSH_EN
            fl_q         <= fl_d;
            flush_done_q <= flush_done_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (dw_en)  data_mem[dw_addr] <= dw_data;
        if (tag_we) tag_mem[tag_wa]   <= tag_wd;
    end

    assign ready_o = (state_q == ST_READY);
    assign valid_o = out_valid_q;
    assign data_o  = data_q;

endmodule
